v_dresizer_ctrl: RTL



---
 rtl/v_dresizer_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/v_dresizer_ctrl.sv
// v_dresizer_ctrl: frame-synchronous sequencer for the 4ppc downsizer; latches decimation
// modes at SOF, tracks beat/line phase and flags stream geometry errors.
module v_dresizer_ctrl #(
    parameter int CNT_W     = 16,
    parameter int EXP_COLS  = 480,
    parameter int EXP_LINES = 1080
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             cfg_enable,
    input  logic             cfg_col_down,
    input  logic             cfg_line_down,
    input  logic             mon_tvalid,
    input  logic             mon_tready,
    input  logic             mon_tuser,
    input  logic             mon_tlast,
    output logic             act_col_down,
    output logic             act_line_down,
    output logic             beat_odd,
    output logic             line_odd,
    output logic             pass_en,
    output logic             busy,
    output logic             frame_done,
    output logic             err_early_eol,
    output logic             err_late_eol,
    output logic             err_sof_mid,
    output logic [CNT_W-1:0] frame_cnt
);
    typedef enum logic [1:0] {IDLE, WAIT_SOF, ACTIVE, RESYNC} state_t;

    localparam logic [CNT_W-1:0] COLS      = CNT_W'(EXP_COLS);
    localparam logic [CNT_W-1:0] LAST_LINE = CNT_W'(EXP_LINES - 1);

    state_t           state_q, state_d;
    logic             act_col_q, act_col_d, act_line_q, act_line_d;
    logic [CNT_W-1:0] beat_q, beat_d, line_q, line_d, frame_q, frame_d, beat_inc;
    logic             done_q, done_d, early_q, early_d, late_q, late_d, sof_mid_q, sof_mid_d;
    logic             beat;

    assign beat     = mon_tvalid & mon_tready;
    assign beat_inc = beat_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        act_col_d  = act_col_q;
        act_line_d = act_line_q;
        beat_d     = beat_q;
        line_d     = line_q;
        frame_d    = frame_q;
        done_d     = 1'b0;
        early_d    = 1'b0;
        late_d     = 1'b0;
        sof_mid_d  = 1'b0;
        case (state_q)
            IDLE: if (cfg_enable) state_d = WAIT_SOF;
            WAIT_SOF, RESYNC: begin
                // an SOF beat is taken even if enable drops in the same cycle, matching pass_en
                if (beat && mon_tuser) begin
                    state_d    = ACTIVE;
                    act_col_d  = cfg_col_down;
                    act_line_d = cfg_line_down;
                    beat_d     = mon_tlast ? '0 : CNT_W'(1);
                    line_d     = mon_tlast ? CNT_W'(1) : '0;
                end else if (!cfg_enable) begin
                    state_d = IDLE;
                end
            end
            ACTIVE: if (beat) begin
                if (mon_tuser) begin
                    sof_mid_d  = 1'b1;
                    act_col_d  = cfg_col_down;
                    act_line_d = cfg_line_down;
                    beat_d     = CNT_W'(1);
                    line_d     = '0;
                end else if (!mon_tlast) begin
                    beat_d = beat_inc;
                    if (beat_inc == COLS) begin
                        late_d  = 1'b1;
                        state_d = RESYNC;
                    end
                end else if (beat_inc < COLS) begin
                    early_d = 1'b1;
                    state_d = RESYNC;
                end else begin
                    beat_d = '0;
                    line_d = line_q + 1'b1;
                    if (line_q == LAST_LINE) begin
                        done_d  = 1'b1;
                        frame_d = frame_q + 1'b1;
                        state_d = cfg_enable ? WAIT_SOF : IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            act_col_q  <= 1'b0;
            act_line_q <= 1'b0;
            beat_q     <= '0;
            line_q     <= '0;
            frame_q    <= '0;
            done_q     <= 1'b0;
            early_q    <= 1'b0;
            late_q     <= 1'b0;
            sof_mid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            act_col_q  <= act_col_d;
            act_line_q <= act_line_d;
            beat_q     <= beat_d;
            line_q     <= line_d;
            frame_q    <= frame_d;
            done_q     <= done_d;
            early_q    <= early_d;
            late_q     <= late_d;
            sof_mid_q  <= sof_mid_d;
        end
    end

    assign act_col_down  = act_col_q;
    assign act_line_down = act_line_q;
    assign beat_odd      = beat_q[0];
    assign line_odd      = line_q[0];
    assign busy          = state_q == ACTIVE;
    assign pass_en       = (state_q == ACTIVE) | (((state_q == WAIT_SOF) | (state_q == RESYNC)) & mon_tuser);
    assign frame_done    = done_q;
    assign err_early_eol = early_q;
    assign err_late_eol  = late_q;
    assign err_sof_mid   = sof_mid_q;
    assign frame_cnt     = frame_q;
endmodule
